// File: rtl/fnd_pkg.sv
// Shared glyphs, FSM encoding and BCD sizing helper for the FND adder/scan path.
package fnd_pkg;

    localparam int unsigned FONT_W = 8;

    localparam logic [FONT_W-1:0] FONT_0     = 8'hC0;
    localparam logic [FONT_W-1:0] FONT_1     = 8'hF9;
    localparam logic [FONT_W-1:0] FONT_2     = 8'hA4;
    localparam logic [FONT_W-1:0] FONT_3     = 8'hB0;
    localparam logic [FONT_W-1:0] FONT_4     = 8'h99;
    localparam logic [FONT_W-1:0] FONT_5     = 8'h92;
    localparam logic [FONT_W-1:0] FONT_6     = 8'h82;
    localparam logic [FONT_W-1:0] FONT_7     = 8'hF8;
    localparam logic [FONT_W-1:0] FONT_8     = 8'h80;
    localparam logic [FONT_W-1:0] FONT_9     = 8'h90;
    localparam logic [FONT_W-1:0] FONT_MINUS = 8'hBF;
    localparam logic [FONT_W-1:0] FONT_BLANK = 8'hFF;
    localparam logic [FONT_W-1:0] FONT_E     = 8'h86;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        CONV   = 2'd2,
        UPDATE = 2'd3
    } fnd_state_e;

    // Active-low segment pattern for one BCD digit; non-decimal codes show 'E'.
    function automatic logic [FONT_W-1:0] font7(input logic [3:0] d);
        logic [FONT_W-1:0] f;
        case (d)
            4'd0:    f = FONT_0;
            4'd1:    f = FONT_1;
            4'd2:    f = FONT_2;
            4'd3:    f = FONT_3;
            4'd4:    f = FONT_4;
            4'd5:    f = FONT_5;
            4'd6:    f = FONT_6;
            4'd7:    f = FONT_7;
            4'd8:    f = FONT_8;
            4'd9:    f = FONT_9;
            default: f = FONT_E;
        endcase
        return f;
    endfunction

    // Number of decimal digits needed to print v.
    function automatic int unsigned clog10(input longint unsigned v);
        int unsigned     n;
        longint unsigned t;
        n = 1;
        t = v;
        while (t >= 64'd10) begin
            t = t / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift-add-3 step per clock, BIN_W steps per conversion.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int unsigned BIN_W  = 9,
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done_c,
    output logic                    ovf,
    output logic [4*(DIGITS+1)-1:0] bcd
);

    localparam longint unsigned MAX_MAG = (64'd1 << BIN_W) - 64'd1;
    localparam int unsigned NEED_N = clog10(MAX_MAG);
    localparam int unsigned BCD_N  = (NEED_N > DIGITS + 1) ? NEED_N : DIGITS + 1;
    localparam int unsigned BCD_W  = 4 * BCD_N;
    localparam int unsigned OUT_W  = 4 * (DIGITS + 1);
    localparam int unsigned CNT_W  = $clog2(BIN_W);

    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj_c;
    logic [BCD_W-1:0] bcd_next_c;
    logic [CNT_W-1:0] cnt_q;

    // Add-3 correction on every nibble, then shift in the next binary bit.
    always_comb begin
        adj_c = bcd_q;
        for (int i = 0; i < int'(BCD_N); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_next_c = {adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
    end

    assign done_c = busy && (cnt_q == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            ovf   <= 1'b0;
        end else if (busy) begin
            bin_q <= bin_q << 1;
            bcd_q <= bcd_next_c;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_c) begin
                busy <= 1'b0;
                ovf  <= (bcd_next_c[BCD_W-1:4*DIGITS] != '0);
            end
        end else if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
        end
    end

    assign bcd = bcd_q[OUT_W-1:0];

endmodule

// File: rtl/fnd_adder_scan.sv
// Add/subtract two registered operands, convert to signed decimal and scan it
// onto a multiplexed common-anode 7-segment display.
module fnd_adder_scan
    import fnd_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic              i_mode,
    input  logic              i_load,
    input  logic              i_en,
    output logic              o_carry,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ovf,
    output logic [DIGITS-1:0] o_digit,
    output logic [7:0]        o_fndFont
);

    localparam int unsigned MAG_W  = WIDTH + 1;
    localparam int unsigned BCD_W  = 4 * (DIGITS + 1);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = $clog2(DIGITS);

    fnd_state_e state_q, state_d;

    logic [WIDTH-1:0]  a_q, b_q;
    logic              mode_q;
    logic              sign_q;
    logic [MAG_W-1:0]  sum_c, diff_c, mag_c;
    logic [WIDTH-1:0]  neg_c;
    logic              sign_c, carry_c;

    logic              start_c;
    logic              conv_busy, conv_done_c, conv_ovf;
    logic [BCD_W-1:0]  conv_bcd;

    logic [7:0]        glyph_c [DIGITS];
    logic [7:0]        glyph_q [DIGITS];
    logic              ovf_c;
    int                msd;

    logic [SCAN_W-1:0] scan_cnt_q;
    logic [IDX_W-1:0]  scan_idx_q;

    // Magnitude/sign split; a borrow means the result is negative.
    always_comb begin
        sum_c  = {1'b0, a_q} + {1'b0, b_q};
        diff_c = {1'b0, a_q} + {1'b0, ~b_q} + MAG_W'(1);
        neg_c  = b_q - a_q;
        if (mode_q) begin
            carry_c = diff_c[WIDTH];
            sign_c  = !diff_c[WIDTH];
            mag_c   = diff_c[WIDTH] ? {1'b0, diff_c[WIDTH-1:0]} : {1'b0, neg_c};
        end else begin
            carry_c = sum_c[WIDTH];
            sign_c  = 1'b0;
            mag_c   = sum_c;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        case (state_q)
            IDLE:   if (i_load) state_d = CALC;
            CALC: begin
                start_c = 1'b1;
                state_d = CONV;
            end
            CONV: begin
                if (conv_done_c)     state_d = UPDATE;
                else if (!conv_busy) state_d = IDLE;
            end
            UPDATE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    bin2bcd_seq #(
        .BIN_W (MAG_W),
        .DIGITS(DIGITS)
    ) u_bcd (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .start (start_c),
        .bin   (mag_c),
        .busy  (conv_busy),
        .done_c(conv_done_c),
        .ovf   (conv_ovf),
        .bcd   (conv_bcd)
    );

    // Glyphs for the new result; a negative value needs one spare position for '-'.
    always_comb begin
        ovf_c = conv_ovf || (conv_bcd[4*DIGITS +: 4] != 4'd0)
             || (sign_q && (conv_bcd[4*(DIGITS-1) +: 4] != 4'd0));
        msd = 0;
        for (int i = 1; i < int'(DIGITS); i++) begin
            if (conv_bcd[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (ovf_c)                       glyph_c[i] = FONT_E;
            else if (i <= msd)               glyph_c[i] = font7(conv_bcd[4*i +: 4]);
            else if (sign_q && i == msd + 1) glyph_c[i] = FONT_MINUS;
            else                             glyph_c[i] = FONT_BLANK;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            sign_q  <= 1'b0;
            o_carry <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_ovf   <= 1'b0;
            for (int i = 0; i < int'(DIGITS); i++) begin
                glyph_q[i] <= (i == 0) ? FONT_0 : FONT_BLANK;
            end
        end else begin
            o_busy <= (state_d != IDLE);
            o_done <= (state_d == UPDATE);
            if (state_q == IDLE && i_load) begin
                a_q    <= i_a;
                b_q    <= i_b;
                mode_q <= i_mode;
            end
            if (state_q == CALC) begin
                o_carry <= carry_c;
                sign_q  <= sign_c;
            end
            if (state_q == UPDATE) begin
                o_ovf <= ovf_c;
                for (int i = 0; i < int'(DIGITS); i++) begin
                    glyph_q[i] <= glyph_c[i];
                end
            end
        end
    end

    // Free-running dwell counter and digit index; i_en only gates the outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            o_digit    <= '1;
            o_fndFont  <= FONT_BLANK;
        end else begin
            if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                scan_idx_q <= (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
            end else begin
                scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
            end
            if (i_en) begin
                o_digit   <= ~(DIGITS'(1) << scan_idx_q);
                o_fndFont <= glyph_q[scan_idx_q];
            end else begin
                o_digit   <= '1;
                o_fndFont <= FONT_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_fnd_adder_scan.sv
// Directed bench: 4-digit and 2-digit instances share stimulus, expected glyphs hand-computed.
module tb_fnd_adder_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       mode, load, en;

    logic       carry4, busy4, done4, ovf4;
    logic [3:0] dig4;
    logic [7:0] font4;
    logic       carry2, busy2, done2, ovf2;
    logic [1:0] dig2;
    logic [7:0] font2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] disp4 [4];
    logic [7:0] disp2 [2];

    always #5 clk = ~clk;

    fnd_adder_scan #(.WIDTH(8), .DIGITS(4), .SCAN_DIV(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_a(a), .i_b(b), .i_mode(mode),
        .i_load(load), .i_en(en), .o_carry(carry4), .o_busy(busy4),
        .o_done(done4), .o_ovf(ovf4), .o_digit(dig4), .o_fndFont(font4)
    );

    fnd_adder_scan #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_a(a), .i_b(b), .i_mode(mode),
        .i_load(load), .i_en(en), .o_carry(carry2), .o_busy(busy2),
        .o_done(done2), .o_ovf(ovf2), .o_digit(dig2), .o_fndFont(font2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watch five dwell slots and record the glyph seen at each anode.
    task automatic capture();
        for (int k = 0; k < 4; k++) disp4[k] = 8'h00;
        for (int k = 0; k < 2; k++) disp2[k] = 8'h00;
        repeat (20) begin
            step();
            for (int k = 0; k < 4; k++) if (dig4[k] == 1'b0) disp4[k] = font4;
            for (int k = 0; k < 2; k++) if (dig2[k] == 1'b0) disp2[k] = font2;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tm, input int inject_at);
        int busy_n, done_n, done_at;
        a = ta; b = tb_v; mode = tm; load = 1'b1;
        step();
        load = 1'b0;
        busy_n = 0; done_n = 0; done_at = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (busy4) busy_n++;
            if (done4) begin
                done_n++;
                if (done_at == 0) done_at = cyc;
            end
            if (cyc == inject_at) begin
                a = 8'd1; b = 8'd1; mode = 1'b0; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
        end
        check({tag, "_busy_cycles"}, busy_n, 11);
        check({tag, "_done_at"}, done_at, 11);
        check({tag, "_done_count"}, done_n, 1);
        capture();
    endtask

    initial begin
        int         done_n;
        int         s;
        logic       found;
        logic [3:0] prev;
        logic [3:0] one4;
        logic [3:0] e4;

        one4 = 4'b0001;
        rst_n = 1'b0; a = '0; b = '0; mode = 1'b0; load = 1'b0; en = 1'b1;
        repeat (3) step();
        check("rst_carry", carry4, 0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_ovf", ovf4, 0);
        check("rst_digit", dig4, 4'hF);
        check("rst_font", font4, 8'hFF);
        check("rst_digit2", dig2, 2'b11);

        #2 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            e4 = ~(one4 << ((k / 4) % 4));
            check($sformatf("scan_order_%0d", k), dig4, e4);
        end
        capture();
        check("rst_display", {disp4[3], disp4[2], disp4[1], disp4[0]}, 32'hFFFFFFC0);
        check("rst_display2", {disp2[1], disp2[0]}, 16'hFFC0);

        run_op("add300", 8'd200, 8'd100, 1'b0, 0);
        check("add300_carry", carry4, 1);
        check("add300_ovf", ovf4, 0);
        check("add300_disp", {disp4[3], disp4[2], disp4[1], disp4[0]}, 32'hFFB0C0C0);
        check("add300_ovf2", ovf2, 1);
        check("add300_disp2", {disp2[1], disp2[0]}, 16'h8686);

        run_op("sub_m4", 8'd5, 8'd9, 1'b1, 0);
        check("sub_m4_carry", carry4, 0);
        check("sub_m4_disp", {disp4[3], disp4[2], disp4[1], disp4[0]}, 32'hFFFFBF99);
        check("sub_m4_disp2", {disp2[1], disp2[0]}, 16'hBF99);
        check("sub_m4_ovf2", ovf2, 0);

        run_op("sub_zero", 8'd9, 8'd9, 1'b1, 0);
        check("sub_zero_carry", carry4, 1);
        check("sub_zero_disp", {disp4[3], disp4[2], disp4[1], disp4[0]}, 32'hFFFFFFC0);

        run_op("inject", 8'd12, 8'd34, 1'b0, 3);
        check("inject_disp", {disp4[3], disp4[2], disp4[1], disp4[0]}, 32'hFFFF9982);

        // Reset in the middle of a conversion.
        a = 8'd200; b = 8'd55; mode = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        repeat (4) step();
        check("midrst_busy_before", busy4, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy4, 0);
        check("midrst_digit", dig4, 4'hF);
        check("midrst_carry", carry4, 0);
        step();
        step();
        rst_n = 1'b1;
        done_n = 0;
        repeat (20) begin
            step();
            if (done4) done_n++;
        end
        check("midrst_no_done", done_n, 0);
        capture();
        check("midrst_disp", {disp4[3], disp4[2], disp4[1], disp4[0]}, 32'hFFFFFFC0);

        run_op("add100", 8'd99, 8'd1, 1'b0, 0);
        check("add100_ovf2", ovf2, 1);
        check("add100_disp2", {disp2[1], disp2[0]}, 16'h8686);
        check("add100_disp", {disp4[3], disp4[2], disp4[1], disp4[0]}, 32'hFFF9C0C0);
        check("add100_ovf", ovf4, 0);

        run_op("sub_m10", 8'd0, 8'd10, 1'b1, 0);
        check("sub_m10_ovf2", ovf2, 1);
        check("sub_m10_disp2", {disp2[1], disp2[0]}, 16'h8686);
        check("sub_m10_disp", {disp4[3], disp4[2], disp4[1], disp4[0]}, 32'hFFBFF9C0);

        run_op("sub_m9", 8'd0, 8'd9, 1'b1, 0);
        check("sub_m9_ovf2", ovf2, 0);
        check("sub_m9_disp2", {disp2[1], disp2[0]}, 16'hBF90);
        check("sub_m9_disp", {disp4[3], disp4[2], disp4[1], disp4[0]}, 32'hFFFFBF90);

        // Display enable: find a slot boundary, blank for 20 cycles, confirm scan phase kept.
        found = 1'b0;
        prev = dig4;
        for (int k = 0; k < 12; k++) begin
            step();
            if (dig4 != prev) begin
                found = 1'b1;
                break;
            end
            prev = dig4;
        end
        check("en_slot_found", found, 1);
        s = 0;
        for (int k = 0; k < 4; k++) if (dig4[k] == 1'b0) s = k;
        en = 1'b0;
        step();
        check("en_off_digit", dig4, 4'hF);
        check("en_off_font", font4, 8'hFF);
        repeat (19) step();
        check("en_off_digit_late", dig4, 4'hF);
        en = 1'b1;
        step();
        e4 = ~(one4 << ((s + 1) % 4));
        check("en_resume_phase", dig4, e4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
